// File: rtl/ann_mac_sequencer.sv
// Per-layer MAC sweep sequencer for the ANN node array.
// Clears accumulators, issues one input index per cycle, drains the MAC pipe.
module ann_mac_sequencer #(
  parameter int MAX_INPUTS = 64,
  parameter int ADDR_W     = 10,
  parameter int PIPE_LAT   = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              reset_accum,
  input  logic [6:0]        max_input,
  input  logic [ADDR_W-1:0] weight_base,
  input  logic              coeff_ready,
  input  logic              src_valid,
  output logic              clear_accum,
  output logic              mac_en,
  output logic [6:0]        in_addr,
  output logic [ADDR_W-1:0] weight_addr,
  output logic              n_start_done,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, RUN, DRAIN, DONE
  } state_t;

  localparam logic [6:0] MAX_L = 7'(MAX_INPUTS);
  localparam logic [2:0] DRAIN_INIT =
    3'(PIPE_LAT > 0 ? PIPE_LAT - 1 : 0);

  state_t            state, state_n;
  logic [6:0]        len_r, len_n;
  logic [6:0]        idx, idx_n;
  logic [ADDR_W-1:0] base_r, base_n;
  logic [2:0]        drain_cnt, drain_n;
  logic              issue;
  logic [6:0]        len_clamp;

  assign issue = coeff_ready & src_valid;
  assign len_clamp = (max_input > MAX_L) ? MAX_L : max_input;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      len_r     <= '0;
      base_r    <= '0;
      idx       <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_n;
      len_r     <= len_n;
      base_r    <= base_n;
      idx       <= idx_n;
      drain_cnt <= drain_n;
    end
  end

  always_comb begin
    state_n      = state;
    len_n        = len_r;
    base_n       = base_r;
    idx_n        = idx;
    drain_n      = drain_cnt;
    clear_accum  = 1'b0;
    mac_en       = 1'b0;
    in_addr      = '0;
    weight_addr  = '0;
    n_start_done = 1'b0;
    busy         = (state != IDLE);
    unique case (state)
      IDLE: begin
      end
      CLEAR: begin
        clear_accum = 1'b1;
        idx_n       = '0;
        state_n     = (len_r == 7'd0) ? DONE : RUN;
      end
      RUN: begin
        mac_en      = issue;
        in_addr     = idx;
        weight_addr = base_r + ADDR_W'(idx);
        if (issue) begin
          idx_n = idx + 7'd1;
          if (idx == len_r - 7'd1) begin
            if (PIPE_LAT > 0) begin
              state_n = DRAIN;
              drain_n = DRAIN_INIT;
            end else begin
              state_n = DONE;
            end
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == 3'd0) state_n = DONE;
        else drain_n = drain_cnt - 3'd1;
      end
      DONE: begin
        n_start_done = 1'b1;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // A strobe in any state restarts the sweep; an aborted one never reports done.
    if (reset_accum) begin
      len_n   = len_clamp;
      base_n  = weight_base;
      state_n = CLEAR;
    end
  end

endmodule

// File: tb/tb_ann_mac_sequencer.sv
// Scoreboard bench for ann_mac_sequencer.
// Expected clear/mac/done events are queued by the driver and checked by a monitor.
module tb_ann_mac_sequencer;

  localparam int AW = 10;
  localparam int PL = 2;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          reset_accum = 1'b0;
  logic [6:0]    max_input = '0;
  logic [AW-1:0] weight_base = '0;
  logic          coeff_ready = 1'b0;
  logic          src_valid = 1'b0;
  logic          clear_accum;
  logic          mac_en;
  logic [6:0]    in_addr;
  logic [AW-1:0] weight_addr;
  logic          n_start_done;
  logic          busy;

  typedef struct {
    int kind;
    int cyc;
    int ia;
    int wa;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  c0;

  ann_mac_sequencer #(
    .MAX_INPUTS(64),
    .ADDR_W(AW),
    .PIPE_LAT(PL)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .reset_accum(reset_accum),
    .max_input(max_input),
    .weight_base(weight_base),
    .coeff_ready(coeff_ready),
    .src_valid(src_valid),
    .clear_accum(clear_accum),
    .mac_en(mac_en),
    .in_addr(in_addr),
    .weight_addr(weight_addr),
    .n_start_done(n_start_done),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input int c, input int ia, input int wa);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.ia   = ia;
    e.wa   = wa;
    exp_q.push_back(e);
  endtask

  task automatic start(input int mi, input int wb);
    reset_accum = 1'b1;
    max_input   = 7'(mi);
    weight_base = AW'(wb);
  endtask

  task automatic expect_sweep(input int s, input int n, input int wb);
    push(0, s + 1, 0, 0);
    for (int i = 0; i < n; i++)
      push(1, s + 2 + i, i, (wb + i) % 1024);
    push(2, s + n + 2 + PL, 0, 0);
  endtask

  task automatic idle_checks(input string tag);
    @(negedge clk);
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_idle_in_addr"}, int'(in_addr), 0);
    chk({tag, "_idle_weight_addr"}, int'(weight_addr), 0);
    chk({tag, "_pending_events"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: every clear/mac/done presentation must match the queue head.
  always @(negedge clk) begin
    int  n;
    int  kind;
    ev_t e;
    n = int'(clear_accum) + int'(mac_en) + int'(n_start_done);
    kind = clear_accum ? 0 : (mac_en ? 1 : 2);
    if (n > 1) begin
      checks++;
      errors++;
      $display("FAIL multi_event: cycle %0d clear %0d mac %0d done %0d",
               cyc, clear_accum, mac_en, n_start_done);
    end else if (n == 1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected",
                 kind, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc ||
            (kind == 1 && (e.ia != int'(in_addr) ||
                           e.wa != int'(weight_addr)))) begin
          errors++;
          $display("FAIL event: got kind %0d cyc %0d ia %0d wa %0h expected kind %0d cyc %0d ia %0d wa %0h",
                   kind, cyc, in_addr, weight_addr, e.kind, e.cyc, e.ia, e.wa);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_clear", int'(clear_accum), 0);
    chk("rst_mac", int'(mac_en), 0);
    chk("rst_done", int'(n_start_done), 0);
    chk("rst_in_addr", int'(in_addr), 0);
    chk("rst_weight_addr", int'(weight_addr), 0);
    tick();
    n_rst = 1'b1;
    coeff_ready = 1'b1;
    src_valid = 1'b1;
    tick();

    // Nominal; mid-sweep input changes must be ignored
    c0 = cyc;
    start(4, 'h100);
    expect_sweep(c0, 4, 'h100);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) begin
        reset_accum = 1'b0;
        max_input = 7'd9;
        weight_base = 'h200;
      end
      @(negedge clk);
      chk("nom_busy", int'(busy), int'(k <= 8));
    end
    idle_checks("nom");

    // Stalls
    tick();
    c0 = cyc;
    start(4, 'h100);
    push(0, c0 + 1, 0, 0);
    push(1, c0 + 2, 0, 'h100);
    push(1, c0 + 4, 1, 'h101);
    push(1, c0 + 6, 2, 'h102);
    push(1, c0 + 7, 3, 'h103);
    push(2, c0 + 10, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) reset_accum = 1'b0;
      src_valid = (k != 3);
      coeff_ready = (k != 5);
      @(negedge clk);
      if (k == 3) begin
        chk("stall_in_addr_held", int'(in_addr), 1);
        chk("stall_mac_low", int'(mac_en), 0);
      end
      chk("stall_busy", int'(busy), int'(k <= 10));
    end
    src_valid = 1'b1;
    coeff_ready = 1'b1;
    idle_checks("stall");

    // Zero length
    tick();
    c0 = cyc;
    start(0, 'h55);
    push(0, c0 + 1, 0, 0);
    push(2, c0 + 2, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 1) reset_accum = 1'b0;
      @(negedge clk);
      chk("zero_busy", int'(busy), int'(k <= 2));
    end
    idle_checks("zero");

    // Clamp to 64 and address wrap
    tick();
    c0 = cyc;
    start(100, 'h3F0);
    expect_sweep(c0, 64, 'h3F0);
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (k == 1) reset_accum = 1'b0;
      @(negedge clk);
      if (k >= 66) chk("clamp_busy", int'(busy), int'(k <= 68));
    end
    idle_checks("clamp");

    // Restart during RUN at idx 3
    tick();
    c0 = cyc;
    start(8, 'h020);
    push(0, c0 + 1, 0, 0);
    for (int i = 0; i < 4; i++) push(1, c0 + 2 + i, i, 'h020 + i);
    push(0, c0 + 6, 0, 0);
    push(1, c0 + 7, 0, 'h040);
    push(1, c0 + 8, 1, 'h041);
    push(2, c0 + 11, 0, 0);
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 1) reset_accum = 1'b0;
      if (k == 5) start(2, 'h040);
      if (k == 6) reset_accum = 1'b0;
      @(negedge clk);
      chk("restart_busy", int'(busy), int'(k <= 11));
    end
    idle_checks("restart");

    // Async reset in DRAIN
    tick();
    c0 = cyc;
    start(4, 'h100);
    push(0, c0 + 1, 0, 0);
    for (int i = 0; i < 4; i++) push(1, c0 + 2 + i, i, 'h100 + i);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) reset_accum = 1'b0;
    end
    n_rst = 1'b0;
    #1;
    chk("areset_busy", int'(busy), 0);
    chk("areset_done", int'(n_start_done), 0);
    chk("areset_mac", int'(mac_en), 0);
    chk("areset_clear", int'(clear_accum), 0);
    tick();
    n_rst = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    idle_checks("areset");

    // Normal sweep after reset
    tick();
    c0 = cyc;
    start(3, 'h010);
    expect_sweep(c0, 3, 'h010);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) reset_accum = 1'b0;
      @(negedge clk);
      chk("post_busy", int'(busy), int'(k <= 7));
    end
    idle_checks("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
